// File: rtl/hazard_forwarding_unit_if.sv
// Pipeline-side signal bundle for the hazard/forwarding unit.
// The pipeline drives the master view, and the unit uses the slave view.
interface hazard_forwarding_unit_if #(
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 16
);
   logic [ADDR_W-1:0] id_r1_addr;
   logic [ADDR_W-1:0] id_r2_addr;
   logic              id_r1_used;
   logic              id_r2_used;
   logic [ADDR_W-1:0] ex_r1_addr;
   logic [ADDR_W-1:0] ex_r2_addr;
   logic              ex_use_imm;
   logic [ADDR_W-1:0] ex_dest;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic [ADDR_W-1:0] mem_dest;
   logic              mem_reg_write;
   logic [ADDR_W-1:0] mem_r2_addr;
   logic              mem_is_store;
   logic [ADDR_W-1:0] wb_dest;
   logic              wb_reg_write;
   logic              flush;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic              store_data_sel;
   logic              stall;
   logic              id_ex_bubble;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output id_r1_addr, id_r2_addr, id_r1_used, id_r2_used,
             ex_r1_addr, ex_r2_addr, ex_use_imm, ex_dest, ex_reg_write, ex_mem_read,
             mem_dest, mem_reg_write, mem_r2_addr, mem_is_store,
             wb_dest, wb_reg_write, flush,
      input  fwd_a_sel, fwd_b_sel, store_data_sel, stall, id_ex_bubble, stall_count
   );

   modport slave (
      input  id_r1_addr, id_r2_addr, id_r1_used, id_r2_used,
             ex_r1_addr, ex_r2_addr, ex_use_imm, ex_dest, ex_reg_write, ex_mem_read,
             mem_dest, mem_reg_write, mem_r2_addr, mem_is_store,
             wb_dest, wb_reg_write, flush,
      output fwd_a_sel, fwd_b_sel, store_data_sel, stall, id_ex_bubble, stall_count
   );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// Forwarding muxes selects plus a load-use stall FSM (LOAD_LATENCY cycles per hazard, flush overrides).
// Forwarding is combinational; optional macro HFU_ZERO_REG_EN makes register 0 never match.
module hazard_forwarding_unit #(
   parameter int ADDR_W       = 3,
   parameter int LOAD_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   hazard_forwarding_unit_if.slave  bus
);
   typedef enum logic {IDLE, STALL} state_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [CNT_W-1:0] stall_cnt;
   logic [1:0]       fwd_a, fwd_b;
   logic             hz, stall, bubble;

   function automatic logic dest_match(input logic [ADDR_W-1:0] dest, input logic [ADDR_W-1:0] src);
`ifdef HFU_ZERO_REG_EN
      return (dest == src) && (dest != '0);
`else
      return dest == src;
`endif
   endfunction

   always_comb begin
      fwd_a = 2'b00;
      if (bus.mem_reg_write && dest_match(bus.mem_dest, bus.ex_r1_addr))
         fwd_a = 2'b01;
      else if (bus.wb_reg_write && dest_match(bus.wb_dest, bus.ex_r1_addr))
         fwd_a = 2'b10;
   end

   always_comb begin
      fwd_b = 2'b00;
      if (bus.ex_use_imm)
         fwd_b = 2'b00;
      else if (bus.mem_reg_write && dest_match(bus.mem_dest, bus.ex_r2_addr))
         fwd_b = 2'b01;
      else if (bus.wb_reg_write && dest_match(bus.wb_dest, bus.ex_r2_addr))
         fwd_b = 2'b10;
   end

   assign hz = bus.ex_reg_write && bus.ex_mem_read &&
               ((bus.id_r1_used && dest_match(bus.ex_dest, bus.id_r1_addr)) ||
                (bus.id_r2_used && dest_match(bus.ex_dest, bus.id_r2_addr)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The first stall cycle is spent in IDLE, so STALL counts down LOAD_LATENCY-1 more cycles.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (bus.flush) begin
         state_nxt = IDLE;
         cnt_nxt   = 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (hz && (LOAD_LATENCY > 1)) begin
                  state_nxt = STALL;
                  cnt_nxt   = 4'(LOAD_LATENCY - 2);
               end
            end
            STALL: begin
               if (cnt == 4'd0)
                  state_nxt = IDLE;
               else
                  cnt_nxt = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      stall  = 1'b0;
      bubble = 1'b0;
      if (!reset) begin
         stall  = 1'b0;
         bubble = 1'b0;
      end else if (bus.flush) begin
         bubble = 1'b1;
      end else begin
         case (state)
            IDLE:    begin stall = hz;   bubble = hz;   end
            STALL:   begin stall = 1'b1; bubble = 1'b1; end
            default: begin stall = 1'b0; bubble = 1'b0; end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cnt <= '0;
      else if (stall && !(&stall_cnt))
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign bus.fwd_a_sel      = fwd_a;
   assign bus.fwd_b_sel      = fwd_b;
   assign bus.store_data_sel = bus.mem_is_store && bus.wb_reg_write &&
                               dest_match(bus.wb_dest, bus.mem_r2_addr);
   assign bus.stall          = stall;
   assign bus.id_ex_bubble   = bubble;
   assign bus.stall_count    = stall_cnt;
endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed bench: forwarding priority, immediate override, store forwarding, load-use stall,
// flush, saturation, asynchronous reset mid-stall and register-0 handling.
module tb_hazard_forwarding_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   failed = 0;

   hazard_forwarding_unit_if #(.ADDR_W(3), .CNT_W(3)) hif();

   hazard_forwarding_unit #(.ADDR_W(3), .LOAD_LATENCY(3), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (hif)
   );

   always #5 clk = ~clk;

`ifdef HFU_ZERO_REG_EN
   localparam bit ZERO = 1'b1;
`else
   localparam bit ZERO = 1'b0;
`endif

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      hif.id_r1_addr = '0;  hif.id_r2_addr = '0;  hif.id_r1_used = 1'b0; hif.id_r2_used = 1'b0;
      hif.ex_r1_addr = '0;  hif.ex_r2_addr = '0;  hif.ex_use_imm = 1'b0;
      hif.ex_dest = '0;     hif.ex_reg_write = 1'b0; hif.ex_mem_read = 1'b0;
      hif.mem_dest = '0;    hif.mem_reg_write = 1'b0; hif.mem_r2_addr = '0; hif.mem_is_store = 1'b0;
      hif.wb_dest = '0;     hif.wb_reg_write = 1'b0;  hif.flush = 1'b0;
   endtask

   task automatic set_load(input logic [2:0] dest, input logic [2:0] src1, input logic used1);
      hif.ex_reg_write = 1'b1; hif.ex_mem_read = 1'b1; hif.ex_dest = dest;
      hif.id_r1_addr = src1;   hif.id_r1_used = used1;
   endtask

   task automatic drop_load();
      hif.ex_reg_write = 1'b0; hif.ex_mem_read = 1'b0;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b0;
      #1;
      check("rst_stall", 16'(hif.stall), 16'd0);
      check("rst_bubble", 16'(hif.id_ex_bubble), 16'd0);
      check("rst_count", 16'(hif.stall_count), 16'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;

      hif.mem_reg_write = 1'b1; hif.mem_dest = 3'd3;
      hif.wb_reg_write = 1'b1;  hif.wb_dest = 3'd3; hif.ex_r1_addr = 3'd3;
      #1 check("fwd_a_prio", 16'(hif.fwd_a_sel), 16'd1);
      hif.mem_reg_write = 1'b0;
      #1 check("fwd_a_wb", 16'(hif.fwd_a_sel), 16'd2);
      hif.ex_r1_addr = 3'd4;
      #1 check("fwd_a_none", 16'(hif.fwd_a_sel), 16'd0);

      hif.wb_dest = 3'd5; hif.ex_r2_addr = 3'd5; hif.ex_use_imm = 1'b0;
      #1 check("fwd_b_wb", 16'(hif.fwd_b_sel), 16'd2);
      hif.ex_use_imm = 1'b1;
      #1 check("fwd_b_imm", 16'(hif.fwd_b_sel), 16'd0);

      hif.mem_is_store = 1'b1; hif.mem_r2_addr = 3'd5;
      #1 check("store_fwd", 16'(hif.store_data_sel), 16'd1);
      hif.mem_r2_addr = 3'd6;
      #1 check("store_nofwd", 16'(hif.store_data_sel), 16'd0);
      clear_inputs();

      set_load(3'd2, 3'd2, 1'b0);
      #1 check("hz_unused", 16'(hif.stall), 16'd0);
      hif.id_r1_used = 1'b1;
      #1 check("ld_stall1", 16'(hif.stall), 16'd1);
      check("ld_bubble1", 16'(hif.id_ex_bubble), 16'd1);
      tick(); drop_load();
      #1 check("ld_stall2", 16'(hif.stall), 16'd1);
      tick();
      #1 check("ld_stall3", 16'(hif.stall), 16'd1);
      tick();
      #1 check("ld_done", 16'(hif.stall), 16'd0);
      check("ld_count", 16'(hif.stall_count), 16'd3);

      set_load(3'd2, 3'd2, 1'b1);
      #1 check("fl_stall1", 16'(hif.stall), 16'd1);
      tick(); drop_load(); hif.flush = 1'b1;
      #1 check("fl_stall", 16'(hif.stall), 16'd0);
      check("fl_bubble", 16'(hif.id_ex_bubble), 16'd1);
      tick(); hif.flush = 1'b0;
      #1 check("fl_idle_stall", 16'(hif.stall), 16'd0);
      check("fl_idle_bubble", 16'(hif.id_ex_bubble), 16'd0);
      check("fl_count", 16'(hif.stall_count), 16'd4);

      set_load(3'd1, 3'd1, 1'b1);
      tick(); drop_load();
      tick(); tick();
      #1 check("sat_reach", 16'(hif.stall_count), 16'd7);
      set_load(3'd1, 3'd1, 1'b1);
      tick(); drop_load();
      #1 check("sat_hold", 16'(hif.stall_count), 16'd7);
      check("mid_stall", 16'(hif.stall), 16'd1);

      set_load(3'd1, 3'd1, 1'b1);
      #2 reset = 1'b0;
      #1 check("arst_stall", 16'(hif.stall), 16'd0);
      check("arst_bubble", 16'(hif.id_ex_bubble), 16'd0);
      check("arst_count", 16'(hif.stall_count), 16'd0);
      drop_load();
      @(negedge clk);
      reset = 1'b1;
      #1 check("rel_stall", 16'(hif.stall), 16'd0);
      tick();
      #1 check("rel_stall2", 16'(hif.stall), 16'd0);
      clear_inputs();

      hif.mem_reg_write = 1'b1; hif.mem_dest = 3'd0; hif.ex_r1_addr = 3'd0;
      #1 check("r0_fwd_a", 16'(hif.fwd_a_sel), ZERO ? 16'd0 : 16'd1);
      hif.mem_reg_write = 1'b0;
      hif.mem_is_store = 1'b1; hif.mem_r2_addr = 3'd0; hif.wb_reg_write = 1'b1; hif.wb_dest = 3'd0;
      #1 check("r0_store", 16'(hif.store_data_sel), ZERO ? 16'd0 : 16'd1);
      clear_inputs();
      set_load(3'd0, 3'd0, 1'b1);
      #1 check("r0_stall", 16'(hif.stall), ZERO ? 16'd0 : 16'd1);
      tick(); drop_load();
      tick(); tick();
      #1 check("r0_end", 16'(hif.stall), 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/hazard_forwarding_unit.md
Name: hazard_forwarding_unit

Overview:
Parametrised forwarding and hazard unit for the 5-stage pipeline.
- Generalises operand forwarding to any register-file size.
- Adds a sequential load-use stall controller that supports a configurable load latency and a branch flush.
- Adds qualified store-data forwarding and a saturating stall-cycle counter.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers; drives the ALU input forwarding muxes, the store-data mux, the PC/IF-ID hold and the ID/EX bubble.

Parameters:
ADDR_W, 3, register address width (2^ADDR_W registers).
LOAD_LATENCY, 1, stall cycles per load-use hazard; legal range 1..15.
CNT_W, 16, stall_count width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
id_r1_addr  input  ADDR_W  source 1 address of the instruction in ID.
id_r2_addr  input  ADDR_W  source 2 address of the instruction in ID.
id_r1_used  input  1  instruction in ID reads source 1.
id_r2_used  input  1  instruction in ID reads source 2.
ex_r1_addr  input  ADDR_W  source 1 address in ID/EX.
ex_r2_addr  input  ADDR_W  source 2 address in ID/EX.
ex_use_imm  input  1  ALU B input takes the immediate.
ex_dest  input  ADDR_W  destination in ID/EX.
ex_reg_write  input  1  ID/EX instruction writes the register file.
ex_mem_read  input  1  ID/EX instruction is a load.
mem_dest  input  ADDR_W  destination in EX/MEM.
mem_reg_write  input  1  EX/MEM instruction writes the register file.
mem_r2_addr  input  ADDR_W  store-data register in EX/MEM.
mem_is_store  input  1  EX/MEM instruction is a store.
wb_dest  input  ADDR_W  destination in MEM/WB.
wb_reg_write  input  1  MEM/WB instruction writes the register file.
flush  input  1  taken branch: squash IF/ID and ID/EX this cycle.
fwd_a_sel  output  2  ALU A select: 00 register file, 01 EX/MEM, 10 MEM/WB.
fwd_b_sel  output  2  ALU B select, same encoding.
store_data_sel  output  1  1: store data taken from the MEM/WB result.
stall  output  1  hold PC and IF/ID.
id_ex_bubble  output  1  load a NOP into ID/EX.
stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
Combinational forwarding, applied every cycle:
- fwd_a_sel = 01 if mem_reg_write and mem_dest==ex_r1_addr. Else 10 if wb_reg_write and wb_dest==ex_r1_addr. Else 00. EX/MEM has priority over MEM/WB.
- fwd_b_sel follows the same rule using ex_r2_addr. It is forced to 00 when ex_use_imm=1.
- store_data_sel = mem_is_store & wb_reg_write & (wb_dest==mem_r2_addr).

Hazard detect, combinational:
- hz = ex_reg_write & ex_mem_read & ((id_r1_used & ex_dest==id_r1_addr) | (id_r2_used & ex_dest==id_r2_addr)).

Stall FSM, states IDLE and STALL, with a 4-bit counter cnt:
- IDLE: stall = id_ex_bubble = hz & ~flush.
  - If hz & ~flush and LOAD_LATENCY>1: go to STALL next cycle with cnt = LOAD_LATENCY-2.
  - Otherwise remain in IDLE.
- STALL: stall = id_ex_bubble = 1. hz is ignored because the load has left EX.
  - If cnt==0: go to IDLE.
  - Else: cnt decrements by 1.
- flush in any state: stall=0 and id_ex_bubble=1 that cycle; next state is IDLE.
- Total stall length per hazard is exactly LOAD_LATENCY cycles.

stall_count:
- Increments by 1 on each clock edge where stall=1.
- Saturates at all-ones and does not wrap.

Reset (reset=0, asynchronous):
- FSM goes to IDLE; cnt=0; stall_count=0.
- stall and id_ex_bubble are 0 while reset is held, including when reset asserts mid-STALL.
- Forwarding outputs stay combinational during reset.

Optional Feature:
Macro HFU_ZERO_REG_EN.
- Defined: register address 0 is hardwired zero. Any comparison whose destination is 0 is false, so there is no forwarding from, store forwarding on, or hazard against register 0.
- Undefined: register 0 is an ordinary register and all comparisons include it.

Test Plan:
- mem_reg_write=1, mem_dest=3, wb_reg_write=1, wb_dest=3, ex_r1_addr=3 -> fwd_a_sel=01 (EX/MEM priority).
- wb_reg_write=1, wb_dest=5, ex_r2_addr=5, ex_use_imm toggled 0 then 1 -> fwd_b_sel=10 then 00.
- LOAD_LATENCY=3: load in EX with ex_dest=2, ID id_r1_addr=2, id_r1_used=1 -> stall=1 for exactly 3 cycles, then 0; stall_count=3.
- LOAD_LATENCY=3: flush=1 in the 2nd stall cycle -> stall=0 and id_ex_bubble=1 that cycle; IDLE next cycle.
- reset driven low mid-STALL -> stall=0 and stall_count=0 immediately, with no clock edge needed; after release, no stall unless hz is present.
- HFU_ZERO_REG_EN defined, mem_reg_write=1, mem_dest=0, ex_r1_addr=0 -> fwd_a_sel=00; load to r0 with dependent ID instruction -> no stall. With the macro undefined, same stimulus -> fwd_a_sel=01 and the stall occurs.
